// File: rtl/alu_uart_sequencer.sv
// Sequences a 3-byte UART frame (A, B, opcode) into the ALU and returns one result byte.
// Latency: opcode byte in cycle N -> EXEC in N+1 -> o_tx_start pulse in N+2.
// Backpressure: one byte in flight; new frames wait for i_tx_done, and bytes arriving while busy are dropped.
module alu_uart_sequencer #(
  parameter int SIZE_OP     = 8,
  parameter int SIZE_COD    = 6,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_done,
  input  logic                i_tx_done,
  input  logic [SIZE_OP-1:0]  i_alu_result,
  output logic [SIZE_OP-1:0]  o_alu_a,
  output logic [SIZE_OP-1:0]  o_alu_b,
  output logic [SIZE_COD-1:0] o_alu_op,
  output logic [7:0]          o_tx_data,
  output logic                o_tx_start,
  output logic                o_busy,
  output logic                o_error
);

  // Counter only has to reach TIMEOUT_CYC-1.
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_GET_A   = 3'd0,
    S_GET_B   = 3'd1,
    S_GET_OP  = 3'd2,
    S_EXEC    = 3'd3,
    S_SEND    = 3'd4,
    S_WAIT_TX = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CW-1:0]       r_cnt;
  logic [SIZE_OP-1:0]  r_alu_a;
  logic [SIZE_OP-1:0]  r_alu_b;
  logic [SIZE_COD-1:0] r_alu_op;
  logic [7:0]          r_tx_data;
  logic                r_error;
  logic [7:0]          w_res_ext;
  logic                w_load_a;
  logic                w_load_b;
  logic                w_load_op;
  logic                w_load_tx;
  logic                w_timeout;
  logic                w_cnt_run;
  logic                w_tx_start;
  logic                w_busy;
  logic                w_cnt_last;

  assign w_cnt_last = (r_cnt == CNT_LAST);

  // Zero-extend the ALU result to a full transmit byte.
  always_comb begin
    w_res_ext                = '0;
    w_res_ext[SIZE_OP-1:0]   = i_alu_result;
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_GET_A;
    else          r_state <= w_next;
  end

  // Next-state and per-state control; a byte on the limit cycle beats the timeout.
  always_comb begin
    w_next     = r_state;
    w_load_a   = 1'b0;
    w_load_b   = 1'b0;
    w_load_op  = 1'b0;
    w_load_tx  = 1'b0;
    w_timeout  = 1'b0;
    w_cnt_run  = 1'b0;
    w_tx_start = 1'b0;
    w_busy     = 1'b0;
    case (r_state)
      S_GET_A: begin
        if (i_rx_done) begin
          w_load_a = 1'b1;
          w_next   = S_GET_B;
        end
      end
      S_GET_B: begin
        if (i_rx_done) begin
          w_load_b = 1'b1;
          w_next   = S_GET_OP;
        end else if (w_cnt_last) begin
          w_timeout = 1'b1;
          w_next    = S_GET_A;
        end else begin
          w_cnt_run = 1'b1;
        end
      end
      S_GET_OP: begin
        if (i_rx_done) begin
          w_load_op = 1'b1;
          w_next    = S_EXEC;
        end else if (w_cnt_last) begin
          w_timeout = 1'b1;
          w_next    = S_GET_A;
        end else begin
          w_cnt_run = 1'b1;
        end
      end
      S_EXEC: begin
        w_busy    = 1'b1;
        w_load_tx = 1'b1;
        w_next    = S_SEND;
      end
      S_SEND: begin
        w_busy     = 1'b1;
        w_tx_start = 1'b1;
        w_next     = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        w_busy = 1'b1;
        if (i_tx_done) w_next = S_GET_A;
      end
      default: w_next = S_GET_A;
    endcase
  end

  // Inter-byte idle counter; any cycle it is not running (byte accepted, other state) clears it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)       r_cnt <= '0;
    else if (w_cnt_run) r_cnt <= r_cnt + CW'(1);
    else                r_cnt <= '0;
  end

  // Operand, opcode and result capture; operands persist across timeouts so the ALU stays stable.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      r_tx_data <= '0;
      r_error   <= 1'b0;
    end else begin
      if (w_load_a)  r_alu_a   <= i_rx_data[SIZE_OP-1:0];
      if (w_load_b)  r_alu_b   <= i_rx_data[SIZE_OP-1:0];
      if (w_load_op) r_alu_op  <= i_rx_data[SIZE_COD-1:0];
      if (w_load_tx) r_tx_data <= w_res_ext;
      r_error <= w_timeout;
    end
  end

  assign o_alu_a    = r_alu_a;
  assign o_alu_b    = r_alu_b;
  assign o_alu_op   = r_alu_op;
  assign o_tx_data  = r_tx_data;
  assign o_tx_start = w_tx_start;
  assign o_busy     = w_busy;
  assign o_error    = r_error;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Bench for alu_uart_sequencer: table-driven frames plus hand-written timeout/reset/busy sequences.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// A behavioural ALU stands in for the real one.
module tb_alu_uart_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] alu_result;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       error;

  int n_checks = 0;
  int n_errors = 0;
  int err_pulses = 0;

  always #5 clk = ~clk;

  alu_uart_sequencer #(.SIZE_OP(8), .SIZE_COD(6), .TIMEOUT_CYC(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_tx_done(tx_done), .i_alu_result(alu_result),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op), .o_tx_data(tx_data),
    .o_tx_start(tx_start), .o_busy(busy), .o_error(error)
  );

  // Behavioural ALU (MIPS-style opcodes).
  always_comb begin
    case (alu_op)
      6'h20:   alu_result = alu_a + alu_b;
      6'h22:   alu_result = alu_a - alu_b;
      6'h24:   alu_result = alu_a & alu_b;
      6'h25:   alu_result = alu_a | alu_b;
      6'h26:   alu_result = alu_a ^ alu_b;
      6'h27:   alu_result = ~(alu_a | alu_b);
      6'h03:   alu_result = 8'($signed(alu_a) >>> alu_b);
      6'h02:   alu_result = alu_a >> alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  // Count every o_error pulse, sampled away from the active edge.
  always @(negedge clk) if (error) err_pulses++;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [5:0] exp_op;
    logic [7:0] exp_tx;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  // Full frame with cycle-exact checks of busy, start pulse and result, then tx completion.
  task automatic run_frame(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [5:0] exp_op,
                           input logic [7:0] exp_tx);
    send_byte(a);
    send_byte(b);
    chk({name, " idle_before_op"}, {31'd0, busy}, 32'd0);
    send_byte(op);
    chk({name, " busy_N+1"}, {31'd0, busy}, 32'd1);
    chk({name, " start_N+1"}, {31'd0, tx_start}, 32'd0);
    tick();
    chk({name, " start_N+2"}, {31'd0, tx_start}, 32'd1);
    chk({name, " tx_data"}, {24'd0, tx_data}, {24'd0, exp_tx});
    chk({name, " alu_op"}, {26'd0, alu_op}, {26'd0, exp_op});
    tick();
    tick();
    chk({name, " start_dropped"}, {31'd0, tx_start}, 32'd0);
    chk({name, " busy_wait_tx"}, {31'd0, busy}, 32'd1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk({name, " busy_after_tx"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_err;
    int base;

    vecs[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08};  // ADD
    vecs[1] = '{8'h03, 8'h05, 8'hE2, 6'h22, 8'hFE};  // SUB, upper opcode bits dropped
    vecs[2] = '{8'h0F, 8'hF0, 8'h24, 6'h24, 8'h00};  // AND
    vecs[3] = '{8'h01, 8'h02, 8'h25, 6'h25, 8'h03};  // OR
    vecs[4] = '{8'h0F, 8'hFF, 8'h26, 6'h26, 8'hF0};  // XOR
    vecs[5] = '{8'h80, 8'h02, 8'h03, 6'h03, 8'hE0};  // SRA
    vecs[6] = '{8'h80, 8'h02, 8'hC2, 6'h02, 8'h20};  // SRL, upper bits dropped
    vecs[7] = '{8'h00, 8'h00, 8'h27, 6'h27, 8'hFF};  // NOR
    vecs[8] = '{8'hFF, 8'h01, 8'h20, 6'h20, 8'h00};  // ADD wraps

    rst_n = 1'b0; rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
    tick(); tick();
    chk("rst alu_a", {24'd0, alu_a}, 32'd0);
    chk("rst alu_b", {24'd0, alu_b}, 32'd0);
    chk("rst alu_op", {26'd0, alu_op}, 32'd0);
    chk("rst tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst outs", {29'd0, tx_start, busy, error}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++)
      run_frame($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
                vecs[i].exp_op, vecs[i].exp_tx);

    // Timeout after operand A: 16 idle cycles in GET_B, exactly one error pulse.
    base = err_pulses;
    send_byte(8'h07);
    first_err = -1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (error && first_err < 0) first_err = t;
    end
    chk("timeout pulse_count", err_pulses - base, 32'd1);
    chk("timeout timing", {31'd0, (first_err == 15 || first_err == 16)}, 32'd1);
    chk("timeout keeps alu_a", {24'd0, alu_a}, 32'h07);
    chk("timeout not busy", {31'd0, busy}, 32'd0);
    run_frame("after_timeout", 8'h01, 8'h02, 8'h25, 6'h25, 8'h03);

    // Byte dropped in WAIT_TX; tx_done during SEND ignored.
    send_byte(8'h05);
    send_byte(8'h03);
    send_byte(8'h20);
    tick();
    chk("seq4 start", {31'd0, tx_start}, 32'd1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("seq4 tx_done_in_send_ignored", {31'd0, busy}, 32'd1);
    send_byte(8'hAA);
    chk("seq4 rx_in_wait_dropped", {24'd0, alu_a}, 32'h05);
    chk("seq4 still_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("seq4 no_restart", {31'd0, tx_start}, 32'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("seq4 released", {31'd0, busy}, 32'd0);
    run_frame("after_drop", 8'h0F, 8'hF0, 8'h24, 6'h24, 8'h00);

    // Reset mid-frame after A and B.
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst alu_a", {24'd0, alu_a}, 32'd0);
    chk("midrst alu_b", {24'd0, alu_b}, 32'd0);
    chk("midrst outs", {29'd0, tx_start, busy, error}, 32'd0);
    run_frame("after_reset", 8'h05, 8'h03, 8'h20, 6'h20, 8'h08);

    // Byte arrives exactly on the timeout-limit cycle in GET_B: accepted, no error.
    base = err_pulses;
    send_byte(8'h09);
    for (int t = 0; t < 15; t++) tick();
    send_byte(8'h04);
    chk("limit byte_as_b", {24'd0, alu_b}, 32'h04);
    send_byte(8'h20);
    tick();
    chk("limit start", {31'd0, tx_start}, 32'd1);
    chk("limit result", {24'd0, tx_data}, 32'h0D);
    chk("limit no_error", err_pulses - base, 32'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
